// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV funct3 size/sign codes (F3_B .. F3_WU)
//   - FSM state enum (IDLE / REQ / WAIT)
//   - size_bytes(): access size in bytes for a funct3 code
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  // Low two bits of funct3 encode log2(size); bit 2 is the unsigned flag.
  function automatic int unsigned size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// lsu_load_extend: combinational load-result formatter.
//   rdata  : lane-aligned read data from memory
//   off    : byte offset of the access within the lane
//   funct3 : RV size/sign code
//   result : rdata shifted down by off bytes, truncated to the access
//            size, then sign- or zero-extended to XLEN
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  localparam int unsigned OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] off,
  input  logic [2:0]       funct3,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    result = shifted;
    case (funct3)
      F3_B:  for (int unsigned i = 8;  i < XLEN; i++) result[i] = shifted[7];
      F3_H:  for (int unsigned i = 16; i < XLEN; i++) result[i] = shifted[15];
      F3_W:  for (int unsigned i = 32; i < XLEN; i++) result[i] = shifted[31];
      F3_BU: for (int unsigned i = 8;  i < XLEN; i++) result[i] = 1'b0;
      F3_HU: for (int unsigned i = 16; i < XLEN; i++) result[i] = 1'b0;
      F3_WU: for (int unsigned i = 32; i < XLEN; i++) result[i] = 1'b0;
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_pipe.sv
// lsu_pipe: XLEN-generic load/store unit for the pipelined RV core.
//   clk, reset          : clock, asynchronous active-high reset
//   req_*               : M-stage op (valid, store flag, funct3, addr,
//                         unaligned store data, load rd); req_ready accepts
//   busy                : unit not idle, feeds the hazard-unit stall
//   mem_req_* / mem_*   : valid/ready request channel to data memory
//                         (lane-aligned addr, we, byte enables, wdata)
//   mem_rsp_valid/rdata : read response channel
//   wb_valid/rd/data    : one-cycle load writeback pulse
//   exc_valid/addr      : one-cycle misaligned/illegal access pulse
module lsu_pipe
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned NB    = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              req_ready,
  output logic              busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [NB-1:0]     mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              exc_valid,
  output logic [ADDR_W-1:0] exc_addr
);

  localparam int unsigned OFF_W = $clog2(NB);

  lsu_state_e state_q, state_d;

  logic              accept;
  logic              f3_ok;
  logic              aligned;
  logic              legal;
  logic [OFF_W-1:0]  req_off;
  logic [2:0]        size_m1;
  logic [XLEN-1:0]   st_data_masked;
  logic [NB-1:0]     st_be_raw;
  logic [XLEN-1:0]   st_wdata;
  logic [NB-1:0]     st_be;

  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [NB-1:0]     mem_be_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [OFF_W-1:0]  ld_off_q;
  logic [2:0]        ld_f3_q;
  logic [4:0]        ld_rd_q;
  logic [XLEN-1:0]   ld_result;

  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [XLEN-1:0]   wb_data_q;
  logic              exc_valid_q;
  logic [ADDR_W-1:0] exc_addr_q;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid & req_ready;
  assign req_off   = req_addr[OFF_W-1:0];

  assign f3_ok   = (req_funct3 != 3'b111) &&
                   !((XLEN == 32) && ((req_funct3 == F3_D) || (req_funct3 == F3_WU)));
  assign size_m1 = 3'(size_bytes(req_funct3) - 1);
  assign aligned = ((req_addr[2:0] & size_m1) == 3'b000);
  assign legal   = f3_ok & aligned;

  // Store alignment: keep only the low size bytes of the data, then move
  // data and enables up to the addressed lane.
  always_comb begin
    st_data_masked = '0;
    st_be_raw      = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (b < size_bytes(req_funct3)) begin
        st_data_masked[8*b +: 8] = req_wdata[8*b +: 8];
        st_be_raw[b]             = 1'b1;
      end
    end
  end

  assign st_wdata = st_data_masked << {req_off, 3'b000};
  assign st_be    = st_be_raw << req_off;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && legal) state_d = REQ;
      REQ:  if (mem_req_ready)   state_d = mem_we_q ? IDLE : WAIT;
      WAIT: if (mem_rsp_valid)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ld_off_q    <= '0;
      ld_f3_q     <= '0;
      ld_rd_q     <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      wb_valid_q  <= 1'b0;
      exc_valid_q <= 1'b0;

      if (accept) begin
        if (legal) begin
          mem_addr_q  <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_we_q    <= req_is_store;
          mem_be_q    <= req_is_store ? st_be : '1;
          mem_wdata_q <= req_is_store ? st_wdata : '0;
          ld_off_q    <= req_off;
          ld_f3_q     <= req_funct3;
          ld_rd_q     <= req_rd;
        end else begin
          exc_valid_q <= 1'b1;
          exc_addr_q  <= req_addr;
        end
      end

      if ((state_q == WAIT) && mem_rsp_valid) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= ld_rd_q;
        wb_data_q  <= ld_result;
      end
    end
  end

  lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem_rdata),
    .off    (ld_off_q),
    .funct3 (ld_f3_q),
    .result (ld_result)
  );

  // ---------------------------------------------------------------------
  // Outputs: the request bus is driven only while REQ so memory never
  // sees stale fields from a completed op.
  // ---------------------------------------------------------------------
  assign mem_req_valid = (state_q == REQ);
  assign mem_addr      = mem_req_valid ? mem_addr_q  : '0;
  assign mem_we        = mem_req_valid ? mem_we_q    : 1'b0;
  assign mem_be        = mem_req_valid ? mem_be_q    : '0;
  assign mem_wdata     = mem_req_valid ? mem_wdata_q : '0;

  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_lsu_pipe.sv
// tb_lsu_pipe: randomized self-checking bench for lsu_pipe, exercising
// an XLEN=32 and an XLEN=64 instance against a behavioural model.
module tb_lsu_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel64;
  logic        req_valid, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_ready, mem_rsp_valid;
  logic [63:0] mem_rdata;

  // XLEN=32 instance outputs
  logic        a_req_ready, a_busy, a_mem_req_valid, a_mem_we, a_wb_valid, a_exc_valid;
  logic [31:0] a_mem_addr, a_mem_wdata, a_wb_data, a_exc_addr;
  logic [3:0]  a_mem_be;
  logic [4:0]  a_wb_rd;
  // XLEN=64 instance outputs
  logic        b_req_ready, b_busy, b_mem_req_valid, b_mem_we, b_wb_valid, b_exc_valid;
  logic [31:0] b_mem_addr, b_exc_addr;
  logic [63:0] b_mem_wdata, b_wb_data;
  logic [7:0]  b_mem_be;
  logic [4:0]  b_wb_rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_pipe #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel64), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
    .req_ready(a_req_ready), .busy(a_busy),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready & ~sel64),
    .mem_addr(a_mem_addr), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_rsp_valid(mem_rsp_valid & ~sel64), .mem_rdata(mem_rdata[31:0]),
    .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data),
    .exc_valid(a_exc_valid), .exc_addr(a_exc_addr)
  );

  lsu_pipe #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel64), .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_ready(b_req_ready), .busy(b_busy),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready & sel64),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_rsp_valid(mem_rsp_valid & sel64), .mem_rdata(mem_rdata),
    .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .exc_valid(b_exc_valid), .exc_addr(b_exc_addr)
  );

  // Observed outputs of whichever instance is selected
  logic        o_req_ready, o_busy, o_mem_req_valid, o_mem_we, o_wb_valid, o_exc_valid;
  logic [31:0] o_mem_addr, o_exc_addr;
  logic [63:0] o_mem_wdata, o_wb_data;
  logic [7:0]  o_mem_be;
  logic [4:0]  o_wb_rd;

  assign o_req_ready     = sel64 ? b_req_ready     : a_req_ready;
  assign o_busy          = sel64 ? b_busy          : a_busy;
  assign o_mem_req_valid = sel64 ? b_mem_req_valid : a_mem_req_valid;
  assign o_mem_we        = sel64 ? b_mem_we        : a_mem_we;
  assign o_wb_valid      = sel64 ? b_wb_valid      : a_wb_valid;
  assign o_exc_valid     = sel64 ? b_exc_valid     : a_exc_valid;
  assign o_mem_addr      = sel64 ? b_mem_addr      : a_mem_addr;
  assign o_exc_addr      = sel64 ? b_exc_addr      : a_exc_addr;
  assign o_mem_wdata     = sel64 ? b_mem_wdata     : {32'h0, a_mem_wdata};
  assign o_wb_data       = sel64 ? b_wb_data       : {32'h0, a_wb_data};
  assign o_mem_be        = sel64 ? b_mem_be        : {4'h0, a_mem_be};
  assign o_wb_rd         = sel64 ? b_wb_rd         : a_wb_rd;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (xlen%0d, t=%0t)", tag, got, exp,
               sel64 ? 64 : 32, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_legal(input int xlen, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = 1 << f3[1:0];
    if (f3 == 3'd7) return 1'b0;
    if (xlen == 32 && (f3 == 3'd3 || f3 == 3'd6)) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [63:0] m_be(input int xlen, input logic [2:0] f3,
                                       input logic [31:0] addr, input bit st);
    logic [127:0] v;
    int sz, nb;
    nb = xlen / 8;
    sz = 1 << f3[1:0];
    if (!st) v = (128'd1 << nb) - 1;
    else     v = ((128'd1 << sz) - 1) << (addr % nb);
    return v[63:0];
  endfunction

  function automatic logic [63:0] m_wdata(input int xlen, input logic [2:0] f3,
                                          input logic [31:0] addr, input logic [63:0] wd);
    logic [127:0] v, mask, xmask;
    int sz, nb;
    nb    = xlen / 8;
    sz    = 1 << f3[1:0];
    mask  = (128'd1 << (8 * sz)) - 1;
    xmask = (128'd1 << xlen) - 1;
    v = ((128'(wd) & mask) << (8 * (addr % nb))) & xmask;
    return v[63:0];
  endfunction

  function automatic logic [63:0] m_load(input int xlen, input logic [2:0] f3,
                                         input logic [31:0] addr, input logic [63:0] rd);
    logic [127:0] v, mask, xmask;
    int sz, nb;
    nb    = xlen / 8;
    sz    = 1 << f3[1:0];
    mask  = (128'd1 << (8 * sz)) - 1;
    xmask = (128'd1 << xlen) - 1;
    v = ((128'(rd) & xmask) >> (8 * (addr % nb))) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    v = v & xmask;
    return v[63:0];
  endfunction

  // ---------------- one complete operation ----------------
  // Entered and left at #1 after a rising edge with the unit idle.
  task automatic do_op(input bit s64, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd,
                       input logic [4:0] rd, input logic [63:0] rdata,
                       input int stall, input int dly);
    int  xlen;
    bit  ok;
    xlen = s64 ? 64 : 32;
    ok   = m_legal(xlen, f3, addr);
    sel64        = s64;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wd;
    req_rd       = rd;
    req_valid    = 1'b1;
    check("req_ready_idle", o_req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("wb_quiet_after_accept", o_wb_valid, 1'b0);
    if (!ok) begin
      check("exc_valid", o_exc_valid, 1'b1);
      check("exc_addr", o_exc_addr, addr);
      check("exc_no_mem", o_mem_req_valid, 1'b0);
      check("exc_req_ready", o_req_ready, 1'b1);
      @(posedge clk); #1;
      check("exc_pulse_end", o_exc_valid, 1'b0);
      return;
    end
    check("no_exc", o_exc_valid, 1'b0);
    for (int s = 0; s <= stall; s++) begin
      check("mem_req_valid", o_mem_req_valid, 1'b1);
      check("busy_req", o_busy, 1'b1);
      check("mem_addr", o_mem_addr, addr & ~32'(xlen / 8 - 1));
      check("mem_we", o_mem_we, st);
      check("mem_be", o_mem_be, m_be(xlen, f3, addr, st));
      if (st) check("mem_wdata", o_mem_wdata, m_wdata(xlen, f3, addr, wd));
      mem_req_ready = (s == stall);
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;
    if (st) begin
      check("st_busy_done", o_busy, 1'b0);
      check("st_no_mem", o_mem_req_valid, 1'b0);
      check("st_no_wb", o_wb_valid, 1'b0);
      return;
    end
    for (int d = 0; d < dly; d++) begin
      check("ld_wait_busy", o_busy, 1'b1);
      check("ld_wait_no_req", o_mem_req_valid, 1'b0);
      check("ld_wait_no_wb", o_wb_valid, 1'b0);
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = rdata;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("wb_valid", o_wb_valid, 1'b1);
    check("wb_rd", o_wb_rd, rd);
    check("wb_data", o_wb_data, m_load(xlen, f3, addr, rdata));
    check("ld_busy_done", o_busy, 1'b0);
    check("ld_ready_on_wb", o_req_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sz;

    reset = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_is_store = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", o_req_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_mem_req_valid", o_mem_req_valid, 1'b0);
    check("rst_wb_valid", o_wb_valid, 1'b0);
    check("rst_exc_valid", o_exc_valid, 1'b0);
    check("rst_mem_be", o_mem_be, 8'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    do_op(1'b0, 1'b1, 3'b000, 32'h1003, 64'hA5, 5'd0, 64'h0, 0, 0);            // sb
    do_op(1'b0, 1'b0, 3'b001, 32'h2002, 64'h0, 5'd5, 64'h80011234, 0, 0);      // lh
    do_op(1'b0, 1'b0, 3'b101, 32'h2002, 64'h0, 5'd5, 64'h80011234, 0, 1);      // lhu
    do_op(1'b0, 1'b0, 3'b010, 32'h0006, 64'h0, 5'd1, 64'h0, 0, 0);             // lw misaligned
    do_op(1'b0, 1'b1, 3'b010, 32'h0010, 64'h12345678, 5'd0, 64'h0, 3, 0);      // sw, ready low 3
    do_op(1'b1, 1'b0, 3'b110, 32'h000C, 64'h0, 5'd9, 64'hDEADBEEF00000000, 0, 0); // lwu xlen64
    do_op(1'b0, 1'b0, 3'b011, 32'h0008, 64'h0, 5'd2, 64'h0, 0, 0);             // ld on xlen32
    do_op(1'b1, 1'b1, 3'b011, 32'h0008, 64'h1122334455667788, 5'd0, 64'h0, 1, 0); // sd xlen64

    // Reset while waiting for a load response; the late response is dropped
    sel64 = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40;
    req_rd = 5'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check("wait_busy", o_busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_req_ready", o_req_ready, 1'b1);
    check("mid_rst_mem_req_valid", o_mem_req_valid, 1'b0);
    check("mid_rst_wb_valid", o_wb_valid, 1'b0);
    check("mid_rst_wb_rd", o_wb_rd, 5'd0);
    check("mid_rst_exc_addr", o_exc_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check("late_rsp_no_wb", o_wb_valid, 1'b0);
    check("late_rsp_idle", o_busy, 1'b0);
    check("late_rsp_wb_data", o_wb_data, 64'h0);

    // Randomized ops, first on the 32-bit unit, then on the 64-bit unit
    for (int i = 0; i < 400; i++) begin
      f3   = 3'($urandom_range(0, 7));
      sz   = 1 << f3[1:0];
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(sz - 1);
      if ($urandom_range(0, 7) == 0) begin
        sel64 = (i >= 200);
        mem_rsp_valid = 1'b1;
        mem_rdata = {$urandom, $urandom};
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        check("idle_rsp_ignored", o_wb_valid, 1'b0);
        check("idle_rsp_busy", o_busy, 1'b0);
      end
      do_op(i >= 200, 1'($urandom_range(0, 1)), f3, addr, {$urandom, $urandom},
            5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 3), $urandom_range(0, 3));
    end

    @(posedge clk); #1;
    check("final_wb_quiet", o_wb_valid, 1'b0);
    check("final_idle", o_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
